// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port round-robin arbiter and access sequencer in front of the shared
// data-memory subsystem. Port 0 is the CPU load/store port and port 1 is the
// DMA/debug-loader port. Only one transaction is in flight at a time. Each
// transaction goes through three states:
//   IDLE   : sample requests and grant one port
//   ACCESS : hold the address/data for MEM_LAT cycles. On the final cycle,
//            pulse mem_we for a store or capture mem_rdata for a load.
//   RESP   : one-cycle ack to the granted port
//
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata      CPU request (req is held until cpu_ack)
//   cpu_ack, cpu_rdata         CPU completion pulse and load data
//   dma_req/we/addr/wdata      DMA request (same handshake as the CPU)
//   dma_ack, dma_rdata         DMA completion pulse and load data
//   mem_addr, mem_wdata        registered address/data to the MMU and arrays
//   mem_we                     single-cycle write strobe
//   mem_rdata                  combinational read data from the arrays
//   busy                       high while in ACCESS or RESP
//   grant_id                   owner of the current/last transaction
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_LAT = 1,   // legal range 1..15
    parameter int AW      = 16,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy,
    output logic          grant_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t        state_reg;
    state_t        state_next;
    logic [3:0]    cnt_reg;
    logic          last_reg;
    logic          we_reg;
    logic          grant_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;

    logic [1:0]    req_vec;
    logic [1:0]    ack_vec;
    logic          grant_valid;
    logic          grant_sel;
    logic          final_cycle;

    assign req_vec     = {dma_req, cpu_req};
    assign grant_valid = |req_vec;
    // On contention, grant the port that did not win last time.
    // Otherwise, grant whichever port is asking.
    assign grant_sel   = (&req_vec) ? ~last_reg : dma_req;
    assign final_cycle = (state_reg == ACCESS) && (cnt_reg == 4'd0);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = ACCESS;
            ACCESS:  if (cnt_reg == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // mem_we is decoded from the state, so it drops as soon as reset is
    // asserted. No partial write can slip through after reset.
    // ---------------------------------------------------------------------
    always_comb begin
        ack_vec = 2'b00;
        mem_we  = 1'b0;
        busy    = (state_reg != IDLE);
        if (final_cycle) begin
            mem_we = we_reg;
        end
        if (state_reg == RESP) begin
            ack_vec[grant_reg] = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Request latch, round-robin pointer and latency counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= 4'd0;
            last_reg  <= 1'b1;   // makes the CPU win the first tie
            we_reg    <= 1'b0;
            grant_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        grant_reg <= grant_sel;
                        last_reg  <= grant_sel;
                        cnt_reg   <= CNT_INIT;
                        if (grant_sel) begin
                            addr_reg  <= dma_addr;
                            wdata_reg <= dma_wdata;
                            we_reg    <= dma_we;
                        end else begin
                            addr_reg  <= cpu_addr;
                            wdata_reg <= cpu_wdata;
                            we_reg    <= cpu_we;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Per-port read-data registers. Each register is written only on the
    // final ACCESS cycle of a load owned by that port, so stores and
    // transactions owned by the other port leave it untouched.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DW-1:0] rdata_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_reg <= '0;
                end else if (final_cycle && !we_reg && (grant_reg == 1'(gi))) begin
                    rdata_reg <= mem_rdata;
                end
            end
        end
    endgenerate

    assign cpu_rdata = g_port[0].rdata_reg;
    assign dma_rdata = g_port[1].rdata_reg;
    assign cpu_ack   = ack_vec[0];
    assign dma_ack   = ack_vec[1];
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign grant_id  = grant_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Testbench for mem_arbiter. It builds two instances of the arbiter:
//   u_lat1  MEM_LAT=1; runs the table-driven transactions and most sequences
//   u_lat4  MEM_LAT=4; runs the long-latency load
// Each instance drives a small word-addressed memory model, indexed by
// addr[9:2]. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // ---------------- instance A (MEM_LAT = 1) ----------------
    logic          a_cpu_req, a_cpu_we, a_cpu_ack;
    logic [AW-1:0] a_cpu_addr;
    logic [DW-1:0] a_cpu_wdata, a_cpu_rdata;
    logic          a_dma_req, a_dma_we, a_dma_ack;
    logic [AW-1:0] a_dma_addr;
    logic [DW-1:0] a_dma_wdata, a_dma_rdata;
    logic [AW-1:0] a_mem_addr;
    logic [DW-1:0] a_mem_wdata, a_mem_rdata;
    logic          a_mem_we, a_busy, a_grant_id;

    // ---------------- instance B (MEM_LAT = 4) ----------------
    logic          b_cpu_req, b_cpu_we, b_cpu_ack;
    logic [AW-1:0] b_cpu_addr;
    logic [DW-1:0] b_cpu_wdata, b_cpu_rdata;
    logic          b_dma_req, b_dma_we, b_dma_ack;
    logic [AW-1:0] b_dma_addr;
    logic [DW-1:0] b_dma_wdata, b_dma_rdata;
    logic [AW-1:0] b_mem_addr;
    logic [DW-1:0] b_mem_wdata, b_mem_rdata;
    logic          b_mem_we, b_busy, b_grant_id;

    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];

    assign a_mem_rdata = mem_a[a_mem_addr[9:2]];
    assign b_mem_rdata = mem_b[b_mem_addr[9:2]];

    always @(posedge clk) begin
        if (a_mem_we) mem_a[a_mem_addr[9:2]] = a_mem_wdata;
        if (b_mem_we) mem_b[b_mem_addr[9:2]] = b_mem_wdata;
    end

    mem_arbiter #(.MEM_LAT(1), .AW(AW), .DW(DW)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr),
        .cpu_wdata(a_cpu_wdata), .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
        .dma_req(a_dma_req), .dma_we(a_dma_we), .dma_addr(a_dma_addr),
        .dma_wdata(a_dma_wdata), .dma_ack(a_dma_ack), .dma_rdata(a_dma_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
        .mem_rdata(a_mem_rdata), .busy(a_busy), .grant_id(a_grant_id)
    );

    mem_arbiter #(.MEM_LAT(4), .AW(AW), .DW(DW)) u_lat4 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
        .cpu_wdata(b_cpu_wdata), .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr),
        .dma_wdata(b_dma_wdata), .dma_ack(b_dma_ack), .dma_rdata(b_dma_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_rdata(b_mem_rdata), .busy(b_busy), .grant_id(b_grant_id)
    );

    typedef struct {
        bit            port;       // 0 = CPU, 1 = DMA
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;  // requester's rdata after the ack
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic set_a_port(input bit port, input logic req, input logic we,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (!port) begin
            a_cpu_req = req; a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = wdata;
        end else begin
            a_dma_req = req; a_dma_we = we; a_dma_addr = addr; a_dma_wdata = wdata;
        end
    endtask

    // Issues one transaction on instance A. Call it on a falling edge while
    // the arbiter is idle.
    task automatic run_txn(input int idx, input vec_t v);
        int n;
        int pulses;
        int oth_acks;
        int addr_bad;
        bit done;
        logic [DW-1:0] oth_before;
        logic [DW-1:0] own_rd;
        logic [DW-1:0] oth_rd;
        logic gid;
        n = 0; pulses = 0; oth_acks = 0; addr_bad = 0; done = 1'b0;
        own_rd = 'x; oth_rd = 'x; gid = 1'bx;
        oth_before = v.port ? a_cpu_rdata : a_dma_rdata;
        set_a_port(v.port, 1'b1, v.we, v.addr, v.wdata);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (a_mem_we) pulses++;
            if (v.port ? a_cpu_ack : a_dma_ack) oth_acks++;
            if (a_busy && (a_mem_addr !== v.addr)) addr_bad++;
            if (v.port ? a_dma_ack : a_cpu_ack) begin
                done   = 1'b1;
                own_rd = v.port ? a_dma_rdata : a_cpu_rdata;
                oth_rd = v.port ? a_cpu_rdata : a_dma_rdata;
                gid    = a_grant_id;
                set_a_port(v.port, 1'b0, 1'b0, '0, '0);
            end
        end
        chk($sformatf("v%0d ack_latency", idx), 32'(n), 32'd2);
        chk($sformatf("v%0d we_pulses", idx), 32'(pulses), v.we ? 32'd1 : 32'd0);
        chk($sformatf("v%0d other_ack", idx), 32'(oth_acks), 32'd0);
        chk($sformatf("v%0d addr_bad", idx), 32'(addr_bad), 32'd0);
        chk($sformatf("v%0d grant_id", idx), 32'(gid), 32'(v.port));
        chk($sformatf("v%0d own_rdata", idx), own_rd, v.exp_rdata);
        chk($sformatf("v%0d other_rdata", idx), oth_rd, oth_before);
        @(negedge clk);
        chk($sformatf("v%0d ack_width", idx), 32'({a_cpu_ack, a_dma_ack, a_busy}), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int acks;
        int both;
        int gap;
        int phase;
        int bad;
        int oth;
        int prev;
        int stable;
        int access_cycles;
        int pulses;
        logic [DW-1:0] hold_val;
        logic [DW-1:0] rd_seen;
        bit first_port;
        bit second_port;
        bit exp_tie [4];
        logic [DW-1:0] exp_tie_rd [4];
        logic [AW-1:0] b2b_addr [3];
        logic [DW-1:0] b2b_rd [3];

        exp_tie    = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_tie_rd = '{32'hA5A50001, 32'hA5A50002, 32'hA5A50001, 32'hA5A50002};
        b2b_addr   = '{16'h0024, 16'h0028, 16'h002C};
        b2b_rd     = '{32'hA5A50009, 32'hA5A5000A, 32'hA5A5000B};

        //           port  we    addr       wdata         exp_rdata
        vecs[0] = '{1'b0, 1'b1, 16'h0004, 32'hDEADBEEF, 32'hA5A50001};
        vecs[1] = '{1'b0, 1'b0, 16'h0004, 32'h00000000, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 16'h0008, 32'hCAFEF00D, 32'hA5A50002};
        vecs[3] = '{1'b1, 1'b0, 16'h0008, 32'h00000000, 32'hCAFEF00D};
        vecs[4] = '{1'b0, 1'b0, 16'h0008, 32'h00000000, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 1'b0, 16'h0004, 32'h00000000, 32'hDEADBEEF};
        vecs[6] = '{1'b0, 1'b1, 16'h0020, 32'h12345678, 32'hCAFEF00D};
        vecs[7] = '{1'b1, 1'b0, 16'h0020, 32'h00000000, 32'h12345678};
        vecs[8] = '{1'b0, 1'b0, 16'h003C, 32'h00000000, 32'hA5A5000F};

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'hA5A50000 | 32'(i);
            mem_b[i] = 32'hB5B50000 | 32'(i);
        end
        mem_b[64] = 32'h12345678;

        a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = '0; a_cpu_wdata = '0;
        a_dma_req = 0; a_dma_we = 0; a_dma_addr = '0; a_dma_wdata = '0;
        b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = '0; b_cpu_wdata = '0;
        b_dma_req = 0; b_dma_we = 0; b_dma_addr = '0; b_dma_wdata = '0;

        // ---------------- reset values ----------------
        repeat (2) @(negedge clk);
        chk("rst ctrl", 32'({a_busy, a_mem_we, a_cpu_ack, a_dma_ack, a_grant_id}), 32'd0);
        chk("rst mem_addr", 32'(a_mem_addr), 32'd0);
        chk("rst mem_wdata", a_mem_wdata, 32'd0);
        chk("rst rdata", a_cpu_rdata | a_dma_rdata, 32'd0);
        chk("rst b ctrl", 32'({b_busy, b_mem_we, b_cpu_ack, b_dma_ack, b_grant_id}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- reset in the middle of a store ----------------
        set_a_port(1'b0, 1'b1, 1'b1, 16'h0010, 32'hAAAA5555);
        @(negedge clk);
        chk("midrst pre busy/we", 32'({a_busy, a_mem_we}), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst we/ack/busy/gid", 32'({a_mem_we, a_cpu_ack, a_dma_ack, a_busy, a_grant_id}), 32'd0);
        chk("midrst mem_addr", 32'(a_mem_addr), 32'd0);
        chk("midrst mem_wdata", a_mem_wdata, 32'd0);
        set_a_port(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("midrst ack during rst", 32'({a_cpu_ack, a_mem_we}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst mem unchanged", mem_a[4], 32'hA5A50004);
        chk("midrst idle after", 32'({a_cpu_ack, a_busy}), 32'd0);

        // ---------------- tie right after reset ----------------
        set_a_port(1'b0, 1'b1, 1'b0, 16'h0004, '0);
        set_a_port(1'b1, 1'b1, 1'b0, 16'h0008, '0);
        acks = 0; n = 0; both = 0; prev = 0;
        while (acks < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (a_cpu_ack && a_dma_ack) both++;
            if (a_cpu_ack || a_dma_ack) begin
                rd_seen = a_dma_ack ? a_dma_rdata : a_cpu_rdata;
                chk($sformatf("tie%0d port", acks), 32'(a_dma_ack), 32'(exp_tie[acks]));
                chk($sformatf("tie%0d grant_id", acks), 32'(a_grant_id), 32'(exp_tie[acks]));
                chk($sformatf("tie%0d rdata", acks), rd_seen, exp_tie_rd[acks]);
                chk($sformatf("tie%0d spacing", acks), 32'(n - prev), (acks == 0) ? 32'd2 : 32'd3);
                prev = n;
                acks++;
                if (acks == 4) begin
                    set_a_port(1'b0, 1'b0, 1'b0, '0, '0);
                    set_a_port(1'b1, 1'b0, 1'b0, '0, '0);
                end else begin
                    @(negedge clk);
                    n++;
                    chk($sformatf("tie%0d ack_width", acks - 1), 32'({a_cpu_ack, a_dma_ack}), 32'd0);
                end
            end
        end
        chk("tie ack_count", 32'(acks), 32'd4);
        chk("tie double_ack", 32'(both), 32'd0);
        @(negedge clk);

        // ---------------- table-driven transactions ----------------
        for (int i = 0; i < 9; i++) begin
            run_txn(i, vecs[i]);
        end

        // ---------------- late arrival ----------------
        set_a_port(1'b0, 1'b1, 1'b0, 16'h0010, '0);
        @(negedge clk);
        chk("late cpu in access", 32'({a_busy, a_grant_id}), 32'd2);
        set_a_port(1'b1, 1'b1, 1'b0, 16'h0020, '0);
        phase = 0; gap = 0; n = 0; first_port = 1'b1; second_port = 1'b0;
        while (phase < 2 && n < 20) begin
            @(negedge clk);
            n++;
            if (a_cpu_ack || a_dma_ack) begin
                if (phase == 0) begin
                    first_port = a_dma_ack;
                    chk("late first rdata", a_cpu_rdata, 32'hA5A50004);
                end else begin
                    second_port = a_dma_ack;
                    chk("late second rdata", a_dma_rdata, 32'h12345678);
                    set_a_port(1'b0, 1'b0, 1'b0, '0, '0);
                    set_a_port(1'b1, 1'b0, 1'b0, '0, '0);
                end
                phase++;
            end else if (phase == 1 && !a_busy) begin
                gap++;
            end
        end
        chk("late first port", 32'(first_port), 32'd0);
        chk("late second port", 32'(second_port), 32'd1);
        chk("late busy gap", 32'(gap), 32'd1);
        @(negedge clk);

        // ---------------- back-to-back CPU loads ----------------
        set_a_port(1'b0, 1'b1, 1'b0, b2b_addr[0], '0);
        acks = 0; n = 0; prev = 0; bad = 0; oth = 0;
        hold_val = a_cpu_rdata;
        while (acks < 3 && n < 30) begin
            @(negedge clk);
            n++;
            if (a_dma_ack) oth++;
            if (a_cpu_ack) begin
                chk($sformatf("b2b%0d rdata", acks), a_cpu_rdata, b2b_rd[acks]);
                chk($sformatf("b2b%0d spacing", acks), 32'(n - prev), (acks == 0) ? 32'd2 : 32'd4 - 32'd1);
                prev = n;
                hold_val = a_cpu_rdata;
                acks++;
                if (acks == 3) set_a_port(1'b0, 1'b0, 1'b0, '0, '0);
                else a_cpu_addr = b2b_addr[acks];
            end else if (a_cpu_rdata !== hold_val) begin
                bad++;
            end
        end
        chk("b2b ack_count", 32'(acks), 32'd3);
        chk("b2b rdata_only_on_ack", 32'(bad), 32'd0);
        chk("b2b dma_ack", 32'(oth), 32'd0);
        @(negedge clk);

        // ---------------- MEM_LAT = 4 DMA load ----------------
        b_dma_req = 1'b1; b_dma_we = 1'b0; b_dma_addr = 16'h0100;
        n = 0; stable = 0; access_cycles = 0; pulses = 0; oth = 0;
        rd_seen = 'x; acks = 0;
        while (acks == 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (b_mem_we) pulses++;
            if (b_cpu_ack) oth++;
            if (b_busy && !b_dma_ack) begin
                access_cycles++;
                if (b_mem_addr === 16'h0100) stable++;
            end
            if (b_dma_ack) begin
                acks = 1;
                rd_seen = b_dma_rdata;
                b_dma_req = 1'b0; b_dma_addr = '0;
            end
        end
        chk("lat4 ack_latency", 32'(n), 32'd5);
        chk("lat4 access_cycles", 32'(access_cycles), 32'd4);
        chk("lat4 addr_stable", 32'(stable), 32'd4);
        chk("lat4 dma_rdata", rd_seen, 32'h12345678);
        chk("lat4 no_we_no_cpu_ack", 32'(pulses + oth), 32'd0);
        @(negedge clk);
        chk("lat4 idle after", 32'({b_dma_ack, b_busy}), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
